// File: rtl/key_pkg.sv
// key_pkg
// Shared constants for the pushbutton step counter feeding the HEX decimal
// display path: counter width and limit, the electrical level of a pressed
// DE2 key, and the default debounce interval (10 ms at 50 MHz).
package key_pkg;

    localparam int                   COUNT_W             = 4;
    localparam logic [COUNT_W-1:0]   COUNT_MAX           = 4'd15;
    localparam logic                 KEY_PRESSED         = 1'b0;
    localparam int                   DEBOUNCE_CYCLES_DEF = 500000;

    // Press events from both keys for one cycle.
    typedef struct packed {
        logic up;
        logic down;
    } press_t;

endpackage

// File: rtl/key_debounce.sv
// key_debounce
// One raw pushbutton -> 2-FF synchroniser -> stability-counter debouncer ->
// single-cycle press pulse on each accepted released-to-pressed transition.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   key_raw  in   raw active-low pushbutton, asynchronous to clk
//   press    out  one-cycle pulse, high the cycle after the accepted level
//                 goes to the pressed state
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic press
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             key_sync;
    logic             acc_q;
    logic             acc_d_q;
    logic [CNT_W-1:0] cnt_q;

    assign key_sync = sync_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= 2'b11;
            acc_q   <= 1'b1;
            acc_d_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], key_raw};
            acc_d_q <= acc_q;
            if (key_sync == acc_q) begin
                // Any return to the accepted level restarts the count.
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                // DEBOUNCE_CYCLES consecutive mismatching samples: accept.
                acc_q <= key_sync;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Releases are ignored; only the edge into the pressed level counts.
    assign press = (acc_d_q != KEY_PRESSED) && (acc_q == KEY_PRESSED);

endmodule

// File: rtl/key_step_counter.sv
// key_step_counter
// Steps a 4-bit value up/down with wrap-around from two debounced DE2
// pushbuttons, with a synchronous parallel load that has priority. COUNT
// feeds the binary-to-decimal HEX decoder directly.
//
// Ports
//   CLOCK_50    in   system clock, rising edge
//   RESET       in   asynchronous active-high reset
//   KEY_UP      in   raw active-low pushbutton, asynchronous
//   KEY_DOWN    in   raw active-low pushbutton, asynchronous
//   LOAD        in   synchronous load enable (wins over key presses)
//   LOAD_VALUE  in   value taken by COUNT while LOAD = 1
//   COUNT       out  current value 0..15
//   STEP        out  one-cycle pulse aligned with a key-driven COUNT change
//   WRAP        out  one-cycle pulse when that step crosses 15->0 or 0->15
module key_step_counter
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic               CLOCK_50,
    input  logic               RESET,
    input  logic               KEY_UP,
    input  logic               KEY_DOWN,
    input  logic               LOAD,
    input  logic [COUNT_W-1:0] LOAD_VALUE,
    output logic [COUNT_W-1:0] COUNT,
    output logic               STEP,
    output logic               WRAP
);

    press_t             ev;
    logic [COUNT_W-1:0] count_nxt;
    logic               step_nxt;
    logic               wrap_nxt;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
        .clk     (CLOCK_50),
        .rst     (RESET),
        .key_raw (KEY_UP),
        .press   (ev.up)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
        .clk     (CLOCK_50),
        .rst     (RESET),
        .key_raw (KEY_DOWN),
        .press   (ev.down)
    );

    // Priority: load, then simultaneous presses cancel, then single press.
    // Presses arriving during a load are dropped, not queued.
    always_comb begin
        count_nxt = COUNT;
        step_nxt  = 1'b0;
        wrap_nxt  = 1'b0;
        if (LOAD) begin
            count_nxt = LOAD_VALUE;
        end else if (ev.up && ev.down) begin
            count_nxt = COUNT;
        end else if (ev.up) begin
            count_nxt = COUNT + 1'b1;
            step_nxt  = 1'b1;
            wrap_nxt  = (COUNT == COUNT_MAX);
        end else if (ev.down) begin
            count_nxt = COUNT - 1'b1;
            step_nxt  = 1'b1;
            wrap_nxt  = (COUNT == '0);
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            COUNT <= '0;
            STEP  <= 1'b0;
            WRAP  <= 1'b0;
        end else begin
            COUNT <= count_nxt;
            STEP  <= step_nxt;
            WRAP  <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_key_step_counter.sv
module tb_key_step_counter;

    localparam int D = 4;

    logic       CLOCK_50 = 1'b0;
    logic       RESET;
    logic       KEY_UP;
    logic       KEY_DOWN;
    logic       LOAD;
    logic [3:0] LOAD_VALUE;
    logic [3:0] COUNT;
    logic       STEP;
    logic       WRAP;

    int errors = 0;
    int checks = 0;

    key_step_counter #(.DEBOUNCE_CYCLES(D)) dut (
        .CLOCK_50   (CLOCK_50),
        .RESET      (RESET),
        .KEY_UP     (KEY_UP),
        .KEY_DOWN   (KEY_DOWN),
        .LOAD       (LOAD),
        .LOAD_VALUE (LOAD_VALUE),
        .COUNT      (COUNT),
        .STEP       (STEP),
        .WRAP       (WRAP)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Reference model: per key, the pin value seen at the last two edges
    // (synchroniser delay), a window of the last D synchronised samples, the
    // accepted level and a pending press event for the next edge.
    bit sp   [2][2];
    bit win  [2][D];
    bit acc  [2];
    bit ev   [2];
    int m_count;
    bit m_step;
    bit m_wrap;

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            sp[k][0] = 1'b1;
            sp[k][1] = 1'b1;
            for (int i = 0; i < D; i++) win[k][i] = 1'b1;
            acc[k] = 1'b1;
            ev[k]  = 1'b0;
        end
        m_count = 0;
        m_step  = 1'b0;
        m_wrap  = 1'b0;
    endfunction

    function automatic void model_edge(bit pu, bit pd, bit ld, bit [3:0] lv);
        bit pin [2];
        bit s;
        bit all_diff;
        pin[0] = pu;
        pin[1] = pd;
        m_step = 1'b0;
        m_wrap = 1'b0;
        if (ld) begin
            m_count = int'(lv);
        end else if (ev[0] && ev[1]) begin
            m_count = m_count;
        end else if (ev[0]) begin
            m_wrap  = (m_count == 15);
            m_count = (m_count + 1) % 16;
            m_step  = 1'b1;
        end else if (ev[1]) begin
            m_wrap  = (m_count == 0);
            m_count = (m_count + 15) % 16;
            m_step  = 1'b1;
        end
        for (int k = 0; k < 2; k++) begin
            s = sp[k][1];
            for (int i = D - 1; i > 0; i--) win[k][i] = win[k][i-1];
            win[k][0] = s;
            all_diff = 1'b1;
            for (int i = 0; i < D; i++) if (win[k][i] == acc[k]) all_diff = 1'b0;
            ev[k] = 1'b0;
            if (all_diff) begin
                acc[k] = ~acc[k];
                ev[k]  = (acc[k] == 1'b0);
            end
            sp[k][1] = sp[k][0];
            sp[k][0] = pin[k];
        end
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        if (!RESET) model_edge(KEY_UP, KEY_DOWN, LOAD, LOAD_VALUE);
        #1;
        chk("model_count", 8'(COUNT), 8'(m_count));
        chk("model_step", 8'(STEP), 8'(m_step));
        chk("model_wrap", 8'(WRAP), 8'(m_wrap));
    endtask

    task automatic hold(input int n, output int steps, output int wraps, output int idx);
        steps = 0;
        wraps = 0;
        idx   = -1;
        for (int i = 0; i < n; i++) begin
            tick();
            if (STEP === 1'b1) begin
                steps++;
                if (idx < 0) idx = i;
            end
            if (WRAP === 1'b1) wraps++;
        end
    endtask

    initial begin
        int st, wr, ix, bst;
        int lv [5];
        int du [5];

        RESET = 1'b1; KEY_UP = 1'b1; KEY_DOWN = 1'b1;
        LOAD = 1'b0; LOAD_VALUE = 4'd0;
        model_reset();
        repeat (3) tick();
        chk("reset_count", 8'(COUNT), 8'd0);
        chk("reset_step", 8'(STEP), 8'd0);
        chk("reset_wrap", 8'(WRAP), 8'd0);
        RESET = 1'b0;

        // Idle keys after reset.
        hold(20, st, wr, ix);
        chk("idle_steps", 8'(st), 8'd0);
        chk("idle_count", 8'(COUNT), 8'd0);

        // Three clean KEY_UP presses.
        for (int p = 0; p < 3; p++) begin
            KEY_UP = 1'b0;
            hold(10, st, wr, ix);
            chk("press_steps", 8'(st), 8'd1);
            chk("press_edge", 8'(ix), 8'd6);
            KEY_UP = 1'b1;
            hold(10, st, wr, ix);
            chk("release_steps", 8'(st), 8'd0);
            chk("press_count", 8'(COUNT), 8'(p + 1));
        end

        // Bouncing KEY_UP: only the final long low counts.
        lv = '{0, 1, 0, 1, 0};
        du = '{2, 1, 2, 1, 10};
        bst = 0;
        for (int s = 0; s < 5; s++) begin
            KEY_UP = lv[s][0];
            hold(du[s], st, wr, ix);
            if (s < 4) bst += st;
            else chk("bounce_final_steps", 8'(st), 8'd1);
        end
        chk("bounce_early_steps", 8'(bst), 8'd0);
        KEY_UP = 1'b1;
        hold(10, st, wr, ix);
        chk("bounce_count", 8'(COUNT), 8'd4);

        // Wrap up from 15, then down from 0.
        LOAD = 1'b1; LOAD_VALUE = 4'd15;
        tick();
        LOAD = 1'b0;
        chk("load15_count", 8'(COUNT), 8'd15);
        KEY_UP = 1'b0;
        hold(10, st, wr, ix);
        chk("wrap_up_count", 8'(COUNT), 8'd0);
        chk("wrap_up_pulses", 8'(wr), 8'd1);
        KEY_UP = 1'b1;
        hold(10, st, wr, ix);
        KEY_DOWN = 1'b0;
        hold(10, st, wr, ix);
        chk("wrap_dn_count", 8'(COUNT), 8'd15);
        chk("wrap_dn_pulses", 8'(wr), 8'd1);
        KEY_DOWN = 1'b1;
        hold(10, st, wr, ix);

        // LOAD on the same edge the KEY_DOWN press would be applied.
        KEY_DOWN = 1'b0;
        hold(6, st, wr, ix);
        LOAD = 1'b1; LOAD_VALUE = 4'd9;
        tick();
        chk("load_vs_press_count", 8'(COUNT), 8'd9);
        chk("load_vs_press_step", 8'(STEP), 8'd0);
        LOAD = 1'b0;
        hold(4, st, wr, ix);
        KEY_DOWN = 1'b1;
        hold(10, st, wr, ix);
        chk("lost_press_count", 8'(COUNT), 8'd9);

        // Both keys pressed together cancel.
        KEY_UP = 1'b0; KEY_DOWN = 1'b0;
        hold(10, st, wr, ix);
        chk("both_steps", 8'(st), 8'd0);
        chk("both_count", 8'(COUNT), 8'd9);
        KEY_UP = 1'b1; KEY_DOWN = 1'b1;
        hold(10, st, wr, ix);

        // Reset mid-debounce, key still held afterwards.
        KEY_UP = 1'b0;
        hold(2, st, wr, ix);
        RESET = 1'b1;
        model_reset();
        #1;
        chk("async_reset_count", 8'(COUNT), 8'd0);
        hold(2, st, wr, ix);
        chk("reset_hold_steps", 8'(st), 8'd0);
        RESET = 1'b0;
        hold(10, st, wr, ix);
        chk("post_reset_steps", 8'(st), 8'd1);
        chk("post_reset_edge", 8'(ix), 8'd6);
        chk("post_reset_count", 8'(COUNT), 8'd1);
        KEY_UP = 1'b1;
        hold(10, st, wr, ix);

        // Random key activity (runs and bounces) with occasional loads.
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 5) == 0) KEY_UP = ~KEY_UP;
            if ($urandom_range(0, 5) == 0) KEY_DOWN = ~KEY_DOWN;
            LOAD = ($urandom_range(0, 19) == 0);
            LOAD_VALUE = 4'($urandom_range(0, 15));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
